usb_rx_bit_decoder: RTL and testbench
=====================================

Name: usb_rx_bit_decoder

Overview:
Bit-level front end of the USB full-speed receive path, the counterpart to the TX serializer. It oversamples the differential D+/D- lines and recovers bit timing from line edges. It NRZI-decodes, detects SYNC, removes stuffed bits, assembles LSB-first bytes and detects EOP. It delivers bytes and packet framing strobes to the RX packet-level FSM.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit; must be even and >= 4.
IDLE_BITS, 8, consecutive J samples required to leave ERROR.

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
dp_in  input  1  raw D+ line, asynchronous to clk
dm_in  input  1  raw D- line, asynchronous to clk
rx_data  output  8  last completed byte; holds until the next byte completes
rx_byte_valid  output  1  1-cycle strobe: rx_data just updated
rx_packet_start  output  1  1-cycle strobe: valid SYNC received
rx_packet_done  output  1  1-cycle strobe: valid EOP received
rx_error  output  1  1-cycle strobe on entry to ERROR
rx_active  output  1  high in SYNC, RECEIVE and EOP states

Behaviour:
- Reset: all outputs 0; state IDLE; prev_level = J; ones_cnt = 0; bit_cnt = 0; shift register = 0; synchronizer flops = J (dp=1, dm=0).
- Reset mid-packet aborts immediately. No strobes are issued for the aborted packet.
- Input sync: dp/dm each pass through a 2-FF synchronizer. Line states: J = 10, K = 01, SE0 = 00, SE1 = 11.
- Bit timer: edge = synced {dp,dm} differs from its value one cycle earlier.
  - On edge: timer <= 0. Otherwise timer increments and wraps CLKS_PER_BIT-1 -> 0.
  - sample strobe fires when timer == CLKS_PER_BIT/2. The timer free-runs in every state.
- NRZI decode on each sample of J or K: bit = 1 if level == prev_level, else 0; then prev_level <= level. SE0 and SE1 samples do not update prev_level.
- States: IDLE, SYNC, RECEIVE, EOP, ERROR.
- IDLE:
  - First K sample -> SYNC. That sample is decoded bit 0 of SYNC (value 0).
  - SE0 and SE1 samples are ignored in IDLE.
- SYNC:
  - Shift 8 decoded bits LSB-first.
  - After the 8th bit: if the byte == 8'h80 (KJKJKJKK), pulse rx_packet_start and go to RECEIVE. Otherwise go to ERROR.
  - Any SE0 or SE1 sample in SYNC -> ERROR.
- RECEIVE:
  - Each decoded bit updates ones_cnt: a 1 increments it, a 0 clears it.
  - When ones_cnt == 6, the next decoded bit is a stuff bit. If it is 0, it is discarded and ones_cnt <= 0. If it is 1, go to ERROR (stuff error).
  - Non-stuff bits shift into the byte LSB-first and bit_cnt increments.
  - On the 8th bit: rx_data <= assembled byte; rx_byte_valid pulses in the clk after the sample strobe; bit_cnt <= 0.
  - ones_cnt carries across byte boundaries.
  - SE0 sample: go to EOP if bit_cnt == 0, otherwise ERROR (EOP mid-byte).
  - SE1 sample -> ERROR.
- EOP:
  - Requires exactly SE0, SE0, J: the first SE0 came from RECEIVE, then one more SE0 sample, then one J sample.
  - Completion: pulse rx_packet_done, set prev_level = J, clear ones_cnt and bit_cnt, go to IDLE.
  - Any other sequence -> ERROR.
- ERROR:
  - rx_error pulses once, on the entry cycle.
  - Stay until IDLE_BITS consecutive J samples, then go to IDLE with prev_level = J.
  - A received byte must never strobe rx_byte_valid after the error.
- Simultaneous events: only one sample strobe occurs per bit, so at most one of byte_valid / packet_done / error can fire per sample.
  - The 8th bit of a byte followed by SE0 gives byte_valid at that bit, then EOP entry at the next sample.
- Width rules: timer width = $clog2(CLKS_PER_BIT); ones_cnt 3 bits; bit_cnt 3 bits, where a wrap 7 -> 0 marks byte completion.

Decomposition:
- Package usb_rx_pkg holds:
  - the state enum rx_state_t {IDLE, SYNC, RECEIVE, EOP, ERROR};
  - line-state constants LINE_J = 2'b10, LINE_K = 2'b01, LINE_SE0 = 2'b00, LINE_SE1 = 2'b11;
  - SYNC_BYTE = 8'h80;
  - STUFF_LIMIT = 6.
- One sub-module: usb_rx_bit_timer. It contains the synchronizers, edge detect and resyncing timer, and outputs sample_strobe and line_state[1:0].
- The top module holds the FSM, NRZI decoder, unstuffer and shift register.

Test Plan:
- Drive SYNC, then byte 8'hA5, then SE0, SE0, J at 8 clk/bit -> one rx_packet_start, then rx_byte_valid with rx_data = 8'hA5, then rx_packet_done; rx_error stays 0.
- Drive SYNC, 8'hFF, 8'h00 with a stuffed 0 after the 6th 1 -> rx_data 8'hFF then 8'h00, exactly 2 byte strobes, no rx_error.
- Drive SYNC, then seven consecutive decoded 1s with no stuffed 0 -> rx_error pulses one clk after the 7th sample; no byte strobe; IDLE is reached after 8 J bit times.
- Drive bad SYNC KJKJKJKJ (decodes to 8'h00) -> rx_error, no rx_packet_start. Then a valid packet with 8'h3C -> received correctly.
- Drive SYNC, 4 data bits, then SE0 -> rx_error and no rx_packet_done. Separately, deassert n_rst mid-byte -> all outputs 0 immediately and the next packet decodes correctly.
- Drive SYNC and 8'h5A with bit edges jittered ±1 clk (7 or 9 clk bits) -> rx_data = 8'h5A, no error.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
//   Shared types and constants for the USB full-speed receive bit decoder.
//   Holds the decoder state enum, the D+/D- line-state encodings, the SYNC
//   pattern as it appears after NRZI decoding, and the bit-stuffing run
//   length.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECEIVE,
    EOP,
    ERROR
  } rx_state_t;

  // Line states as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  // KJKJKJKK decoded LSB-first from an idle J line
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // After this many consecutive 1s the transmitter inserts a 0
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Only J and K carry data; SE0/SE1 are framing or fault conditions
  function automatic logic is_data_level(input logic [1:0] level);
    return (level == LINE_J) || (level == LINE_K);
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer
//   Synchronizes the raw D+/D- lines into the clk domain and recovers bit
//   timing. A timer restarts on every line transition and free-runs between
//   transitions, so the sample point stays centred in each bit even when the
//   sender's clock drifts slightly.
//
// Ports:
//   clk, n_rst     system clock, asynchronous active-low reset
//   dp_in, dm_in   raw USB lines, asynchronous to clk
//   sample_strobe  high for one clk at the middle of each bit
//   line_state     synchronized {dp, dm}
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic       sample_strobe,
  output logic [1:0] line_state
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_HALF = TW'(CLKS_PER_BIT / 2);

  logic          dp_meta;
  logic          dp_sync;
  logic          dm_meta;
  logic          dm_sync;
  logic [1:0]    line_prev;
  logic [TW-1:0] timer;
  logic          line_edge;

  // Two-flop synchronizers; they come out of reset showing an idle J line
  // so the decoder does not see a spurious transition after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta <= 1'b1;
      dp_sync <= 1'b1;
      dm_meta <= 1'b0;
      dm_sync <= 1'b0;
    end else begin
      dp_meta <= dp_in;
      dp_sync <= dp_meta;
      dm_meta <= dm_in;
      dm_sync <= dm_meta;
    end
  end

  assign line_state = {dp_sync, dm_sync};
  assign line_edge  = (line_state != line_prev);

  // Bit timer: any transition realigns the bit boundary, otherwise the
  // timer wraps once per nominal bit period so runs of identical levels
  // still produce one sample per bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_prev <= LINE_J;
      timer     <= '0;
    end else begin
      line_prev <= line_state;
      if (line_edge) begin
        timer <= '0;
      end else if (timer == TIMER_LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign sample_strobe = (timer == TIMER_HALF);

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder
//   Bit-level front end of the USB full-speed receive path. Samples the line
//   once per bit (via usb_rx_bit_timer), NRZI-decodes, checks SYNC, strips
//   stuffed bits, assembles LSB-first bytes and recognises EOP.
//
// Ports:
//   clk, n_rst       system clock, asynchronous active-low reset
//   dp_in, dm_in     raw USB lines, asynchronous to clk
//   rx_data          last completed byte, held until the next one
//   rx_byte_valid    1-clk strobe, rx_data just updated
//   rx_packet_start  1-clk strobe, valid SYNC seen
//   rx_packet_done   1-clk strobe, valid EOP seen
//   rx_error         1-clk strobe on entering ERROR
//   rx_active        high while in SYNC, RECEIVE or EOP
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int IDLE_BITS    = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic [7:0] rx_data,
  output logic       rx_byte_valid,
  output logic       rx_packet_start,
  output logic       rx_packet_done,
  output logic       rx_error,
  output logic       rx_active
);

  localparam int ICW = $clog2(IDLE_BITS + 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_BITS - 1);

  logic           sample_strobe;
  logic [1:0]     line_state;

  rx_state_t      state;
  rx_state_t      state_next;
  logic [1:0]     prev_level;
  logic [1:0]     prev_level_next;
  logic [2:0]     ones_cnt;
  logic [2:0]     ones_cnt_next;
  logic [2:0]     bit_cnt;
  logic [2:0]     bit_cnt_next;
  logic [7:0]     shift_reg;
  logic [7:0]     shift_reg_next;
  logic           eop_second;
  logic           eop_second_next;
  logic [ICW-1:0] idle_cnt;
  logic [ICW-1:0] idle_cnt_next;
  logic [7:0]     rx_data_next;
  logic           byte_valid_next;
  logic           start_next;
  logic           done_next;
  logic           error_next;
  logic           go_error;

  logic           decoded_bit;
  logic [7:0]     assembled;
  logic           data_level;

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .dp_in        (dp_in),
    .dm_in        (dm_in),
    .sample_strobe(sample_strobe),
    .line_state   (line_state)
  );

  // NRZI: no transition means 1. New bits enter at the MSB so that after
  // eight shifts the first bit received sits in bit 0.
  assign decoded_bit = (line_state == prev_level);
  assign assembled   = {decoded_bit, shift_reg[7:1]};
  assign data_level  = is_data_level(line_state);

  // State and datapath registers. Strobes are registered, so each one
  // appears in the clk after the sample that caused it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      prev_level      <= LINE_J;
      ones_cnt        <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      eop_second      <= 1'b0;
      idle_cnt        <= '0;
      rx_data         <= '0;
      rx_byte_valid   <= 1'b0;
      rx_packet_start <= 1'b0;
      rx_packet_done  <= 1'b0;
      rx_error        <= 1'b0;
    end else begin
      state           <= state_next;
      prev_level      <= prev_level_next;
      ones_cnt        <= ones_cnt_next;
      bit_cnt         <= bit_cnt_next;
      shift_reg       <= shift_reg_next;
      eop_second      <= eop_second_next;
      idle_cnt        <= idle_cnt_next;
      rx_data         <= rx_data_next;
      rx_byte_valid   <= byte_valid_next;
      rx_packet_start <= start_next;
      rx_packet_done  <= done_next;
      rx_error        <= error_next;
    end
  end

  // Next-state logic. Nothing moves except on a sample strobe; every fault
  // path funnels through go_error so ERROR entry is handled in one place.
  always_comb begin
    state_next      = state;
    prev_level_next = prev_level;
    ones_cnt_next   = ones_cnt;
    bit_cnt_next    = bit_cnt;
    shift_reg_next  = shift_reg;
    eop_second_next = eop_second;
    idle_cnt_next   = idle_cnt;
    rx_data_next    = rx_data;
    byte_valid_next = 1'b0;
    start_next      = 1'b0;
    done_next       = 1'b0;
    error_next      = 1'b0;
    go_error        = 1'b0;

    if (sample_strobe) begin
      case (state)
        IDLE: begin
          // The first K is also the first SYNC bit (decodes to 0)
          if (line_state == LINE_K) begin
            state_next      = SYNC;
            prev_level_next = LINE_K;
            shift_reg_next  = assembled;
            bit_cnt_next    = 3'd1;
          end
        end

        SYNC: begin
          if (!data_level) begin
            go_error = 1'b1;
          end else begin
            prev_level_next = line_state;
            shift_reg_next  = assembled;
            bit_cnt_next    = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (assembled == SYNC_BYTE) begin
                state_next    = RECEIVE;
                start_next    = 1'b1;
                ones_cnt_next = '0;
              end else begin
                go_error = 1'b1;
              end
            end
          end
        end

        RECEIVE: begin
          if (line_state == LINE_SE0) begin
            if (bit_cnt == 3'd0) begin
              state_next      = EOP;
              eop_second_next = 1'b0;
            end else begin
              go_error = 1'b1;
            end
          end else if (line_state == LINE_SE1) begin
            go_error = 1'b1;
          end else begin
            prev_level_next = line_state;
            if (ones_cnt == STUFF_LIMIT) begin
              // Stuffed bit: a 0 is dropped, a 1 means the sender broke
              // the stuffing rule
              if (decoded_bit) begin
                go_error = 1'b1;
              end else begin
                ones_cnt_next = '0;
              end
            end else begin
              ones_cnt_next  = decoded_bit ? (ones_cnt + 3'd1) : 3'd0;
              shift_reg_next = assembled;
              bit_cnt_next   = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data_next    = assembled;
                byte_valid_next = 1'b1;
              end
            end
          end
        end

        EOP: begin
          if (!eop_second) begin
            if (line_state == LINE_SE0) begin
              eop_second_next = 1'b1;
            end else begin
              go_error = 1'b1;
            end
          end else if (line_state == LINE_J) begin
            state_next      = IDLE;
            done_next       = 1'b1;
            prev_level_next = LINE_J;
            ones_cnt_next   = '0;
            bit_cnt_next    = '0;
            eop_second_next = 1'b0;
          end else begin
            go_error = 1'b1;
          end
        end

        ERROR: begin
          // Wait for a clean run of idle J before listening again
          if (line_state == LINE_J) begin
            if (idle_cnt == IDLE_LAST) begin
              state_next      = IDLE;
              prev_level_next = LINE_J;
              idle_cnt_next   = '0;
              ones_cnt_next   = '0;
              bit_cnt_next    = '0;
            end else begin
              idle_cnt_next = idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt_next = '0;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    if (go_error) begin
      state_next      = ERROR;
      error_next      = 1'b1;
      idle_cnt_next   = '0;
      ones_cnt_next   = '0;
      bit_cnt_next    = '0;
      eop_second_next = 1'b0;
    end
  end

  assign rx_active = (state == SYNC) || (state == RECEIVE) || (state == EOP);

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb_usb_rx_bit_decoder
//   Directed bench for usb_rx_bit_decoder. A small NRZI/bit-stuffing encoder
//   drives the lines; a monitor counts strobes and records received bytes.
module tb_usb_rx_bit_decoder;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dp_in = 1'b1;
  logic       dm_in = 1'b0;
  logic [7:0] rx_data;
  logic       rx_byte_valid;
  logic       rx_packet_start;
  logic       rx_packet_done;
  logic       rx_error;
  logic       rx_active;

  int total = 0;
  int bad = 0;

  int         n_start = 0;
  int         n_done = 0;
  int         n_err = 0;
  logic [7:0] byte_q[$];
  int         b_start, b_done, b_err, b_bytes;

  logic [1:0] level = LINE_J;
  int         ones = 0;
  bit         jitter = 1'b0;
  bit         jtog = 1'b0;

  usb_rx_bit_decoder #(
    .CLKS_PER_BIT(8),
    .IDLE_BITS   (8)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .dp_in          (dp_in),
    .dm_in          (dm_in),
    .rx_data        (rx_data),
    .rx_byte_valid  (rx_byte_valid),
    .rx_packet_start(rx_packet_start),
    .rx_packet_done (rx_packet_done),
    .rx_error       (rx_error),
    .rx_active      (rx_active)
  );

  always #5 clk = ~clk;

  // Monitor: counts strobe cycles and records each delivered byte
  always @(negedge clk) begin
    if (rx_byte_valid) byte_q.push_back(rx_data);
    if (rx_packet_start) n_start++;
    if (rx_packet_done) n_done++;
    if (rx_error) n_err++;
  end

  task automatic drive(input logic [1:0] lvl, input int clks);
    {dp_in, dm_in} = lvl;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_raw(input logic b);
    int n;
    if (!b) level = (level == LINE_J) ? LINE_K : LINE_J;
    n = 8;
    if (jitter) begin
      jtog = !jtog;
      n = jtog ? 7 : 9;
    end
    drive(level, n);
  endtask

  task automatic send_data(input logic b);
    send_raw(b);
    if (b) begin
      ones++;
      if (ones == 6) begin
        send_raw(1'b0);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = SYNC_BYTE;
    level = LINE_J;
    for (int i = 0; i < 8; i++) send_raw(s[i]);
    ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data(b[i]);
  endtask

  task automatic idle_bits(input int n);
    level = LINE_J;
    drive(LINE_J, 8 * n);
  endtask

  task automatic send_eop();
    drive(LINE_SE0, 16);
    idle_bits(4);
  endtask

  task automatic mark();
    b_start = n_start;
    b_done  = n_done;
    b_err   = n_err;
    b_bytes = byte_q.size();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    drive(LINE_J, 3);
    total++;
    if (rx_data !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data);
    end
    total++;
    if ({rx_byte_valid, rx_packet_start, rx_packet_done, rx_error, rx_active} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b expected 00000",
        {rx_byte_valid, rx_packet_start, rx_packet_done, rx_error, rx_active});
    end
    n_rst = 1'b1;
    mark();
    idle_bits(4);
    total++;
    if (rx_active !== 1'b0 || n_err != b_err) begin
      bad++; $display("[TB] FAIL idle_quiet: active %b errors %0d expected 0 0", rx_active, n_err - b_err);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    mark();
    send_sync();
    send_byte(8'hA5);
    send_eop();
    got = (byte_q.size() > b_bytes) ? byte_q[b_bytes] : 8'hxx;
    total++;
    if (n_start - b_start != 1) begin
      bad++; $display("[TB] FAIL a5_start: got %0d expected 1", n_start - b_start);
    end
    total++;
    if (byte_q.size() - b_bytes != 1 || got !== 8'hA5) begin
      bad++; $display("[TB] FAIL a5_byte: got %0d bytes first %h expected 1 A5", byte_q.size() - b_bytes, got);
    end
    total++;
    if (n_done - b_done != 1 || n_err != b_err) begin
      bad++; $display("[TB] FAIL a5_frame: got done %0d err %0d expected 1 0", n_done - b_done, n_err - b_err);
    end
    total++;
    if (rx_data !== 8'hA5 || rx_active !== 1'b0) begin
      bad++; $display("[TB] FAIL a5_hold: got data %h active %b expected A5 0", rx_data, rx_active);
    end
  endtask

  task automatic test_stuffing();
    logic [7:0] g0, g1;
    mark();
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_eop();
    g0 = (byte_q.size() > b_bytes) ? byte_q[b_bytes] : 8'hxx;
    g1 = (byte_q.size() > b_bytes + 1) ? byte_q[b_bytes + 1] : 8'hxx;
    total++;
    if (byte_q.size() - b_bytes != 2 || g0 !== 8'hFF || g1 !== 8'h00) begin
      bad++; $display("[TB] FAIL stuff_bytes: got %0d bytes %h %h expected 2 FF 00", byte_q.size() - b_bytes, g0, g1);
    end
    total++;
    if (n_err != b_err || n_done - b_done != 1) begin
      bad++; $display("[TB] FAIL stuff_frame: got err %0d done %0d expected 0 1", n_err - b_err, n_done - b_done);
    end
  endtask

  task automatic test_stuff_error();
    logic [7:0] got;
    mark();
    send_sync();
    repeat (6) send_raw(1'b1);
    total++;
    if (n_err != b_err) begin
      bad++; $display("[TB] FAIL stuff_err_early: got %0d expected 0", n_err - b_err);
    end
    send_raw(1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (n_err - b_err != 1) begin
      bad++; $display("[TB] FAIL stuff_err_pulse: got %0d expected 1", n_err - b_err);
    end
    idle_bits(10);
    total++;
    if (n_err - b_err != 1 || byte_q.size() != b_bytes || n_done != b_done || rx_active !== 1'b0) begin
      bad++; $display("[TB] FAIL stuff_err_after: got err %0d bytes %0d done %0d active %b expected 1 0 0 0",
        n_err - b_err, byte_q.size() - b_bytes, n_done - b_done, rx_active);
    end
    mark();
    send_sync();
    send_byte(8'h7E);
    send_eop();
    got = (byte_q.size() > b_bytes) ? byte_q[b_bytes] : 8'hxx;
    total++;
    if (got !== 8'h7E || n_err != b_err || n_done - b_done != 1) begin
      bad++; $display("[TB] FAIL recover_7e: got %h err %0d done %0d expected 7E 0 1", got, n_err - b_err, n_done - b_done);
    end
  endtask

  task automatic test_bad_sync();
    logic [7:0] got;
    mark();
    level = LINE_J;
    repeat (8) send_raw(1'b0);
    idle_bits(10);
    total++;
    if (n_err - b_err != 1 || n_start != b_start) begin
      bad++; $display("[TB] FAIL bad_sync: got err %0d start %0d expected 1 0", n_err - b_err, n_start - b_start);
    end
    mark();
    send_sync();
    send_byte(8'h3C);
    send_eop();
    got = (byte_q.size() > b_bytes) ? byte_q[b_bytes] : 8'hxx;
    total++;
    if (got !== 8'h3C || n_start - b_start != 1 || n_done - b_done != 1 || n_err != b_err) begin
      bad++; $display("[TB] FAIL after_bad_sync: got %h start %0d done %0d err %0d expected 3C 1 1 0",
        got, n_start - b_start, n_done - b_done, n_err - b_err);
    end
  endtask

  task automatic test_eop_mid_byte();
    mark();
    send_sync();
    send_data(1'b1);
    send_data(1'b0);
    send_data(1'b1);
    send_data(1'b0);
    drive(LINE_SE0, 16);
    idle_bits(10);
    total++;
    if (n_err - b_err != 1 || n_done != b_done || byte_q.size() != b_bytes) begin
      bad++; $display("[TB] FAIL eop_mid_byte: got err %0d done %0d bytes %0d expected 1 0 0",
        n_err - b_err, n_done - b_done, byte_q.size() - b_bytes);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] got;
    send_sync();
    send_data(1'b1);
    send_data(1'b0);
    send_data(1'b1);
    total++;
    if (rx_active !== 1'b1 || rx_data !== 8'h3C) begin
      bad++; $display("[TB] FAIL pre_reset: got active %b data %h expected 1 3C", rx_active, rx_data);
    end
    n_rst = 1'b0;
    #1;
    total++;
    if ({rx_data, rx_byte_valid, rx_packet_start, rx_packet_done, rx_error, rx_active} !== 13'h0) begin
      bad++; $display("[TB] FAIL mid_reset: got data %h flags %b expected 00 00000", rx_data,
        {rx_byte_valid, rx_packet_start, rx_packet_done, rx_error, rx_active});
    end
    level = LINE_J;
    ones = 0;
    drive(LINE_J, 3);
    n_rst = 1'b1;
    idle_bits(4);
    mark();
    send_sync();
    send_byte(8'hC3);
    send_eop();
    got = (byte_q.size() > b_bytes) ? byte_q[b_bytes] : 8'hxx;
    total++;
    if (got !== 8'hC3 || n_start - b_start != 1 || n_done - b_done != 1 || n_err != b_err) begin
      bad++; $display("[TB] FAIL after_reset: got %h start %0d done %0d err %0d expected C3 1 1 0",
        got, n_start - b_start, n_done - b_done, n_err - b_err);
    end
  endtask

  task automatic test_jitter();
    logic [7:0] got;
    mark();
    jitter = 1'b1;
    jtog = 1'b0;
    send_sync();
    send_byte(8'h5A);
    jitter = 1'b0;
    send_eop();
    got = (byte_q.size() > b_bytes) ? byte_q[b_bytes] : 8'hxx;
    total++;
    if (got !== 8'h5A || byte_q.size() - b_bytes != 1) begin
      bad++; $display("[TB] FAIL jitter_byte: got %h count %0d expected 5A 1", got, byte_q.size() - b_bytes);
    end
    total++;
    if (n_err != b_err || n_start - b_start != 1 || n_done - b_done != 1) begin
      bad++; $display("[TB] FAIL jitter_frame: got err %0d start %0d done %0d expected 0 1 1",
        n_err - b_err, n_start - b_start, n_done - b_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuffing();
    test_stuff_error();
    test_bad_sync();
    test_eop_mid_byte();
    test_reset_mid_packet();
    test_jitter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
